// File: rtl/square_list_to_bitboard.sv
// Square-list to bitboard collector.
// Accepts a stream of binary square indices terminated by in_last and
// presents the OR of their one-hot decodes, together with a saturating
// beat count, a duplicate flag and an out-of-range flag. The result is
// held until the consumer takes it; no new list is accepted meanwhile.
module square_list_to_bitboard #(
  parameter  int ONEHOT_WIDTH = 64,
  localparam int BIN_WIDTH    = $clog2(ONEHOT_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BIN_WIDTH-1:0]    in_bin,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ONEHOT_WIDTH-1:0] out_bitboard,
  output logic [BIN_WIDTH:0]      out_count,
  output logic                    out_dup,
  output logic                    out_range
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Indices are compared one bit wider so widths like 48 are detected.
  localparam logic [BIN_WIDTH:0]      LIMIT      = ONEHOT_WIDTH[BIN_WIDTH:0];
  localparam logic [BIN_WIDTH:0]      CNT_MAX    = '1;
  localparam logic [BIN_WIDTH:0]      CNT_ONE    = {{BIN_WIDTH{1'b0}}, 1'b1};
  localparam logic [ONEHOT_WIDTH-1:0] ONEHOT_ONE = {{(ONEHOT_WIDTH-1){1'b0}}, 1'b1};

  state_t                  state_q;
  logic [ONEHOT_WIDTH-1:0] acc_q, acc_d;
  logic [BIN_WIDTH:0]      cnt_q, cnt_d;
  logic                    dup_q, dup_d;
  logic                    rng_q, rng_d;
  logic [ONEHOT_WIDTH-1:0] out_bb_q;
  logic [BIN_WIDTH:0]      out_cnt_q;
  logic                    out_dup_q;
  logic                    out_rng_q;

  logic                    in_range;
  logic [ONEHOT_WIDTH-1:0] onehot;

  // Next accumulator/flag/count values assuming the current beat is accepted.
  always_comb begin
    in_range = {1'b0, in_bin} < LIMIT;
    onehot   = in_range ? (ONEHOT_ONE << in_bin) : '0;
    acc_d    = acc_q | onehot;
    dup_d    = dup_q | (|(acc_q & onehot));
    rng_d    = rng_q | ~in_range;
    cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
  end

  // Collect beats in ACCUM, snapshot the result on the last beat, then
  // present it in HOLD until the consumer handshakes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      cnt_q     <= '0;
      dup_q     <= 1'b0;
      rng_q     <= 1'b0;
      out_bb_q  <= '0;
      out_cnt_q <= '0;
      out_dup_q <= 1'b0;
      out_rng_q <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_valid) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            dup_q <= dup_d;
            rng_q <= rng_d;
            if (in_last) begin
              out_bb_q  <= acc_d;
              out_cnt_q <= cnt_d;
              out_dup_q <= dup_d;
              out_rng_q <= rng_d;
              state_q   <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            dup_q   <= 1'b0;
            rng_q   <= 1'b0;
            state_q <= ACCUM;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign in_ready     = (state_q == ACCUM);
  assign out_valid    = (state_q == HOLD);
  assign out_bitboard = out_bb_q;
  assign out_count    = out_cnt_q;
  assign out_dup      = out_dup_q;
  assign out_range    = out_rng_q;

endmodule

// File: tb/tb_square_list_to_bitboard.sv
// Bench for square_list_to_bitboard: directed lists plus random lists on a
// 64-wide and a 48-wide instance, checked against a set-based list model.
module tb_square_list_to_bitboard;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 64-wide instance
  logic        a_in_valid = 1'b0, a_in_last = 1'b0, a_out_ready = 1'b0;
  logic [5:0]  a_in_bin = '0;
  logic        a_in_ready, a_out_valid, a_out_dup, a_out_range;
  logic [63:0] a_out_bb;
  logic [6:0]  a_out_count;

  // 48-wide instance
  logic        b_in_valid = 1'b0, b_in_last = 1'b0, b_out_ready = 1'b0;
  logic [5:0]  b_in_bin = '0;
  logic        b_in_ready, b_out_valid, b_out_dup, b_out_range;
  logic [47:0] b_out_bb;
  logic [6:0]  b_out_count;

  square_list_to_bitboard #(.ONEHOT_WIDTH(64)) dut64 (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_bin(a_in_bin), .in_last(a_in_last),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_bitboard(a_out_bb),
    .out_count(a_out_count), .out_dup(a_out_dup), .out_range(a_out_range)
  );

  square_list_to_bitboard #(.ONEHOT_WIDTH(48)) dut48 (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_bin(b_in_bin), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_bitboard(b_out_bb),
    .out_count(b_out_count), .out_dup(b_out_dup), .out_range(b_out_range)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: the list as a set of squares.
  task automatic model(input int q[$], input int w, output logic [63:0] bb,
                       output int cnt, output logic dup, output logic rng);
    bit seen[64];
    bb = '0; dup = 1'b0; rng = 1'b0;
    foreach (seen[k]) seen[k] = 1'b0;
    foreach (q[i]) begin
      if (q[i] >= w) rng = 1'b1;
      else begin
        if (seen[q[i]]) dup = 1'b1;
        seen[q[i]] = 1'b1;
        bb[q[i]] = 1'b1;
      end
    end
    cnt = (q.size() > 127) ? 127 : q.size();
  endtask

  task automatic drive(input int which, input logic v, input logic [5:0] b, input logic l);
    if (which == 0) begin a_in_valid = v; a_in_bin = b; a_in_last = l; end
    else            begin b_in_valid = v; b_in_bin = b; b_in_last = l; end
  endtask

  task automatic set_ordy(input int which, input logic r);
    if (which == 0) a_out_ready = r; else b_out_ready = r;
  endtask

  task automatic check_out(input string tag, input int which, input logic [63:0] bb,
                           input int cnt, input logic dup, input logic rng);
    if (which == 0) begin
      chk({tag, ".out_valid"}, 64'(a_out_valid), 64'd1);
      chk({tag, ".in_ready"},  64'(a_in_ready),  64'd0);
      chk({tag, ".bitboard"},  a_out_bb,         bb);
      chk({tag, ".count"},     64'(a_out_count), 64'(cnt));
      chk({tag, ".dup"},       64'(a_out_dup),   64'(dup));
      chk({tag, ".range"},     64'(a_out_range), 64'(rng));
    end else begin
      chk({tag, ".out_valid"}, 64'(b_out_valid), 64'd1);
      chk({tag, ".in_ready"},  64'(b_in_ready),  64'd0);
      chk({tag, ".bitboard"},  {16'h0, b_out_bb}, bb);
      chk({tag, ".count"},     64'(b_out_count), 64'(cnt));
      chk({tag, ".dup"},       64'(b_out_dup),   64'(dup));
      chk({tag, ".range"},     64'(b_out_range), 64'(rng));
    end
  endtask

  // Send a list, check the held result for hold+1 cycles (with junk input
  // offered while held), then handshake and check the return to ACCUM.
  task automatic run_list(input string tag, input int which, input int q[$],
                          input bit early, input int hold);
    logic [63:0] bb; int cnt; logic dup, rng;
    model(q, (which == 0) ? 64 : 48, bb, cnt, dup, rng);
    set_ordy(which, early);
    foreach (q[i]) begin
      @(negedge clk);
      drive(which, 1'b1, 6'(q[i]), (i == q.size() - 1));
    end
    @(negedge clk);
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) @(negedge clk);
      check_out(tag, which, bb, cnt, dup, rng);
      if (h == hold) begin
        drive(which, 1'b0, '0, 1'b0);
        set_ordy(which, 1'b1);
      end else begin
        drive(which, 1'b1, 6'($urandom_range(0, 63)), 1'($urandom));
      end
    end
    @(negedge clk);
    if (which == 0) begin
      chk({tag, ".post_valid"}, 64'(a_out_valid), 64'd0);
      chk({tag, ".post_ready"}, 64'(a_in_ready),  64'd1);
    end else begin
      chk({tag, ".post_valid"}, 64'(b_out_valid), 64'd0);
      chk({tag, ".post_ready"}, 64'(b_in_ready),  64'd1);
    end
    set_ordy(which, 1'b0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, ".a_valid"}, 64'(a_out_valid), 64'd0);
    chk({tag, ".a_bb"},    a_out_bb,         64'd0);
    chk({tag, ".a_count"}, 64'(a_out_count), 64'd0);
    chk({tag, ".a_dup"},   64'(a_out_dup),   64'd0);
    chk({tag, ".a_range"}, 64'(a_out_range), 64'd0);
    chk({tag, ".b_valid"}, 64'(b_out_valid), 64'd0);
    chk({tag, ".b_bb"},    {16'h0, b_out_bb}, 64'd0);
  endtask

  initial begin
    int q[$];
    int len, hi, hold;
    bit early;

    // Reset state
    #12;
    chk_reset_outs("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset.a_in_ready", 64'(a_in_ready), 64'd1);
    chk("reset.b_in_ready", 64'(b_in_ready), 64'd1);

    // Three distinct squares, consumer always ready
    q = {0, 7, 63};
    run_list("corners", 0, q, 1'b1, 0);
    chk("corners.bb_const", a_out_bb, 64'h8000_0000_0000_0081);

    // Repeated square
    q = {12, 12};
    run_list("dup12", 0, q, 1'b0, 0);

    // Out-of-range index on the 48-wide instance
    q = {5, 50};
    run_list("range48", 1, q, 1'b0, 0);

    // Held result with back-pressure, then a single-beat list
    q = {3};
    run_list("hold3", 0, q, 1'b0, 5);
    q = {4};
    run_list("single4", 0, q, 1'b0, 0);

    // Reset mid-list discards the partial list
    @(negedge clk); drive(0, 1'b1, 6'd1, 1'b0);
    @(negedge clk); drive(0, 1'b1, 6'd2, 1'b0);
    @(negedge clk); drive(0, 1'b0, '0, 1'b0);
    #2 rst = 1'b1;
    #1 chk_reset_outs("midrst");
    @(negedge clk); rst = 1'b0;
    q = {9};
    run_list("after_rst", 0, q, 1'b0, 0);

    // Reset while holding a result
    @(negedge clk); drive(0, 1'b1, 6'd20, 1'b1);
    @(negedge clk); drive(0, 1'b0, '0, 1'b0);
    chk("holdrst.pre_valid", 64'(a_out_valid), 64'd1);
    #2 rst = 1'b1;
    #1 chk_reset_outs("holdrst");
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("holdrst.in_ready", 64'(a_in_ready), 64'd1);

    // Counter saturation
    q.delete();
    for (int i = 0; i < 201; i++) q.push_back(0);
    run_list("sat", 0, q, 1'b0, 0);

    // Random lists
    for (int n = 0; n < 24; n++) begin
      q.delete();
      len  = $urandom_range(1, 10);
      hi   = ($urandom_range(0, 2) == 0) ? 7 : 63;
      for (int i = 0; i < len; i++) q.push_back($urandom_range(0, hi));
      hold  = $urandom_range(0, 3);
      early = (hold == 0) ? 1'($urandom) : 1'b0;
      run_list((n % 2 == 0) ? "rand64" : "rand48", n % 2, q, early, hold);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/square_list_to_bitboard.md
SQUARE_LIST_TO_BITBOARD -- requirements
Module: square_list_to_bitboard

Interface
REQ-001 SHALL have parameter ONEHOT_WIDTH, default 64, meaning bitboard width (one bit per square).
REQ-002 SHALL have localparam BIN_WIDTH = $clog2(ONEHOT_WIDTH), meaning square-index width (6 at default).
REQ-003 SHALL have port clk, input, 1, the single clock; all state SHALL be updated on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; it SHALL be asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, meaning a square index is offered.
REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts an index this cycle.
REQ-007 SHALL have port in_bin, input, BIN_WIDTH, the binary square index.
REQ-008 SHALL have port in_last, input, 1, meaning this index is the final index of the current list.
REQ-009 SHALL have port out_valid, output, 1, meaning a completed bitboard is presented.
REQ-010 SHALL have port out_ready, input, 1, meaning the consumer takes the bitboard.
REQ-011 SHALL have port out_bitboard, output, ONEHOT_WIDTH, the OR of the one-hot decodes of all list indices.
REQ-012 SHALL have port out_count, output, BIN_WIDTH+1, the number of beats accepted in the list.
REQ-013 SHALL have port out_dup, output, 1, meaning at least one index in the list repeated an earlier bit.
REQ-014 SHALL have port out_range, output, 1, meaning at least one index was >= ONEHOT_WIDTH.

Function
REQ-015 SHALL implement two states: ACCUM (collecting indices) and HOLD (presenting a result).
REQ-016 SHALL drive in_ready=1 in ACCUM and in_ready=0 in HOLD; out_valid SHALL be 1 exactly in HOLD.
REQ-017 SHALL treat an input beat as accepted iff in_valid && in_ready on a rising clk edge.
REQ-018 SHALL decode an accepted in_bin to a one-hot vector with only bit in_bin set, and OR it into an internal accumulator.
REQ-019 SHALL ignore an index >= ONEHOT_WIDTH for the bitboard, set a sticky range flag, and still count the beat.
REQ-020 SHALL set a sticky dup flag when the accepted index's bit is already set in the accumulator.
REQ-021 SHALL increment the beat counter per accepted beat, saturating at 2^(BIN_WIDTH+1)-1 without wrapping.
REQ-022 SHALL, on an accepted beat with in_last=1, load out_bitboard/out_count/out_dup/out_range with values including that beat and enter HOLD; latency from last-beat edge to out_valid=1 is one cycle.
REQ-023 SHALL hold all out_* values stable while out_valid=1 and out_ready=0.
REQ-024 SHALL, on out_valid && out_ready, return to ACCUM with accumulator, counter, dup and range flags cleared; in_ready becomes 1 in the following cycle (no same-cycle pass-through).
REQ-025 SHALL ignore in_valid, in_bin and in_last in HOLD.
REQ-026 SHALL treat a single-beat list (first beat has in_last=1) as a complete list of count 1.
REQ-027 SHALL retain out_* register contents after the handshake until the next list completes; they are meaningful only while out_valid=1.

Reset
REQ-028 SHALL, on rst=1 at any time including mid-list or in HOLD, immediately force state ACCUM, accumulator 0, counter 0, flags 0, out_valid 0, out_bitboard 0, out_count 0, out_dup 0, out_range 0.
REQ-029 SHALL drive in_ready=1 from the first clock edge after rst deasserts; a partially accumulated list SHALL be discarded.

Verification
REQ-030 SHALL verify: beats 0, 7, 63(last) with out_ready=1 -> next cycle out_valid=1, out_bitboard=0x8000_0000_0000_0081, out_count=3, out_dup=0, out_range=0.
REQ-031 SHALL verify: beats 12, 12(last) -> out_bitboard=0x1000, out_count=2, out_dup=1.
REQ-032 SHALL verify: ONEHOT_WIDTH=48, beats 5, 50(last) -> out_bitboard=0x20, out_count=2, out_range=1.
REQ-033 SHALL verify: list 3(last) with out_ready=0 for 5 cycles -> in_ready=0 and out_* stable throughout; out_ready=1 -> out_valid=0 next cycle, in_ready=1; next list 4(last) -> out_bitboard=0x10, out_count=1.
REQ-034 SHALL verify: beats 1, 2 then rst pulse mid-cycle, then 9(last) -> all outputs 0 during reset, result out_bitboard=0x200, out_count=1.
REQ-035 SHALL verify: 200 beats of index 0 then last -> out_count=127 (saturated), out_bitboard=0x1, out_dup=1.
